// File: rtl/ob_mk_queue.sv
// ob_mk_queue: per-side FIFO of resting market orders with lazy cancel-by-uid
//   clk, rst_n                      clock, async active-low reset
//   push_vld/push_data/push_rdy     enqueue a new order (accepted on vld & rdy)
//   head_vld_r/head_r               oldest live order (registered)
//   upd_vld/upd_consumed/upd_remainder  trade result: pop head or rewrite its quantity
//   cncl_vld/cncl_uid/cncl_hit_r    cancel by uid; hit reported next cycle
//   empty_r/full_r/occupancy_r      status; occupancy counts killed entries too
package ob_pkg;
    typedef logic [15:0] uid_t;
    typedef logic [15:0] price_t;
    typedef logic [15:0] quantity_t;
    typedef struct packed {
        uid_t      uid;
        price_t    price;
        quantity_t quantity;
    } table_t;
endpackage

module ob_mk_queue
    import ob_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_vld,
    input  table_t               push_data,
    output logic                 push_rdy,
    output logic                 head_vld_r,
    output table_t               head_r,
    input  logic                 upd_vld,
    input  logic                 upd_consumed,
    input  quantity_t            upd_remainder,
    input  logic                 cncl_vld,
    input  uid_t                 cncl_uid,
    output logic                 cncl_hit_r,
    output logic                 empty_r,
    output logic                 full_r,
    output logic [$clog2(N):0]   occupancy_r
);
    localparam int AW = $clog2(N);
    localparam int PW = AW + 1;

    table_t          mem_q [N];
    logic [N-1:0]    kill_q, kill_d, live_q, live_d, match;
    logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
    logic [AW-1:0]   rd_idx, wr_idx, rd_idx_d;
    logic            head_vld_q, head_vld_d, hit_q, hit_d;
    table_t          head_q, head_d;
    logic            empty, full, push, drain, pop, rewrite;

    assign rd_idx      = rd_q[AW-1:0];
    assign wr_idx      = wr_q[AW-1:0];
    assign empty       = rd_q == wr_q;
    assign full        = (rd_q[AW] != wr_q[AW]) && (rd_idx == wr_idx);
    assign push        = push_vld && !full;
    // a killed head is skipped one entry per cycle
    assign drain       = !empty && kill_q[rd_idx];
    assign pop         = (upd_vld && upd_consumed) || drain;
    assign rewrite     = upd_vld && !upd_consumed;
    assign push_rdy    = !full;
    assign empty_r     = empty;
    assign full_r      = full;
    assign occupancy_r = wr_q - rd_q;
    assign head_vld_r  = head_vld_q;
    assign head_r      = head_q;
    assign cncl_hit_r  = hit_q;

    always_comb begin
        rd_d     = rd_q + PW'(pop);
        wr_d     = wr_q + PW'(push);
        rd_idx_d = rd_d[AW-1:0];
        // a head popped by the trade this cycle is no longer cancellable
        for (int i = 0; i < N; i++)
            match[i] = cncl_vld && live_q[i] && !kill_q[i] && (mem_q[i].uid == cncl_uid) &&
                       !(upd_vld && upd_consumed && AW'(i) == rd_idx);
        hit_d  = |match;
        kill_d = kill_q | match;
        live_d = live_q;
        if (pop) begin
            live_d[rd_idx] = 1'b0;
            kill_d[rd_idx] = 1'b0;
        end
        if (push) begin
            live_d[wr_idx] = 1'b1;
            kill_d[wr_idx] = 1'b0;
        end
        // forward the rewrite and any push landing at the new head
        head_d = mem_q[rd_idx_d];
        if (rewrite)
            head_d.quantity = upd_remainder;
        if (push && wr_idx == rd_idx_d)
            head_d = push_data;
        head_vld_d = (rd_d != wr_d) && !kill_d[rd_idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            wr_q       <= '0;
            kill_q     <= '0;
            live_q     <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
            hit_q      <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            kill_q     <= kill_d;
            live_q     <= live_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            hit_q      <= hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_idx] <= push_data;
        if (rewrite)
            mem_q[rd_idx].quantity <= upd_remainder;
    end

    a_upd_on_head: assert property (@(posedge clk) disable iff (!rst_n) upd_vld |-> head_vld_q);
    a_rem_nonzero: assert property (@(posedge clk) disable iff (!rst_n)
                                    (upd_vld && !upd_consumed) |-> (upd_remainder != '0));
endmodule
